// File: rtl/ifetch_buffer.sv
// Sequential instruction fetch with a DEPTH-entry buffer feeding decode over valid/ready.
// Optional macro IFETCH_ALIGN_CHECK_EN adds misalign_err and halts fetch on unaligned redirects.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,output logic       misalign_err
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     addr_q, addr_d;
    logic            req_q, req_d;
    logic            drop_q, drop_d;
    logic            mis_q, mis_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_ir_q, out_ir_d;
    logic [31:0]     out_pc_q, out_pc_d;

    logic            ack_s, pop_s, push_s, hold_s, start_s;
    logic [31:0]     redir_pc_s;
    logic            redir_mis_s;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign redir_pc_s  = redirect_pc;
    assign redir_mis_s = (redirect_pc[1:0] != 2'b00);
`else
    assign redir_pc_s  = redirect_pc & 32'hFFFF_FFFC;
    assign redir_mis_s = 1'b0;
`endif

    // Next-state for the buffer, fetch PC, drop flag and request handshake.
    always_comb begin
        ack_s       = imem_ack & req_q;
        pop_s       = out_valid_q & out_ready;
        push_s      = ack_s & ~drop_q;
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        fetch_pc_d  = fetch_pc_q;
        drop_d      = drop_q;
        mis_d       = mis_q;
        addr_d      = addr_q;
        req_d       = 1'b0;
        hold_s      = 1'b0;
        start_s     = 1'b0;
        out_valid_d = 1'b0;
        out_ir_d    = out_ir_q;
        out_pc_d    = out_pc_q;

        if (redirect_en) begin
            // Flush wins over any same-cycle push or pop; a still-pending response gets dropped.
            rd_ptr_d   = {AW{1'b0}};
            wr_ptr_d   = {AW{1'b0}};
            count_d    = {CW{1'b0}};
            fetch_pc_d = redir_pc_s;
            mis_d      = redir_mis_s;
            if (ack_s) begin
                drop_d = 1'b0;
            end else if (req_q) begin
                drop_d = 1'b1;
            end else begin
                drop_d = drop_q;
            end
        end else begin
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s) begin
                mem_d[wr_ptr_q] = '{ir: imem_rdata, pc: addr_q};
                wr_ptr_d        = wr_ptr_q + AW'(1);
                fetch_pc_d      = addr_q + 32'd4;
            end else begin
                wr_ptr_d   = wr_ptr_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (ack_s && drop_q) begin
                drop_d = 1'b0;
            end else begin
                drop_d = drop_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end

        // A new request needs a guaranteed free slot for its response.
        hold_s  = req_q & ~ack_s;
        start_s = ~hold_s & (count_d < CW'(DEPTH)) & ~mis_d;
        req_d   = hold_s | start_s;
        if (start_s) begin
            addr_d = fetch_pc_d;
        end else begin
            addr_d = addr_q;
        end

        out_valid_d = (count_d != {CW{1'b0}});
        if (out_valid_d) begin
            out_ir_d = mem_d[rd_ptr_d].ir;
            out_pc_d = mem_d[rd_ptr_d].pc;
        end else begin
            out_ir_d = out_ir_q;
            out_pc_d = out_pc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= {AW{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            fetch_pc_q  <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            drop_q      <= 1'b0;
            mis_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_ir_q    <= 32'h0000_0000;
            out_pc_q    <= 32'h0000_0000;
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            fetch_pc_q  <= fetch_pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            drop_q      <= drop_d;
            mis_q       <= mis_d;
            out_valid_q <= out_valid_d;
            out_ir_q    <= out_ir_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = out_valid_q;
    assign out_ir    = out_ir_q;
    assign out_pc    = out_pc_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign_err = mis_q;
`endif

endmodule

// File: tb/tb_ifetch_buffer.sv
// Bench for ifetch_buffer: directed sequences, a redirect vector table and a random run
// checked against a queue-based model of the fetch stream.
module tb_ifetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_ack, out_valid, out_ready, redirect_en;
    logic [31:0] imem_addr, imem_rdata, out_ir, out_pc, redirect_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    ifetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,.misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic [31:0] ir; } ent_t;
    typedef struct { logic [31:0] rpc; logic [31:0] a0; logic [31:0] a1; } vec_t;

    int errors = 0;
    int checks = 0;

    ent_t        mq[$];
    logic [31:0] req_log[$], ack_log[$], pop_log[$];
    logic [31:0] m_next_pc;
    bit          m_drop, m_mis;
    int          cur_lat, wait_cnt;
    bit          rand_lat;
    bit          ready_v, redir_v;
    logic [31:0] rpc_v;
    bit          trig_en, trig_ack, trig_hit;
    logic [31:0] trig_addr, trig_pc;
    bit          prev_hold;
    logic [31:0] prev_addr;
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_idx(input string name, input bit use_pop, input int idx, input logic [31:0] exp);
        int n;
        n = use_pop ? pop_log.size() : req_log.size();
        if (idx >= n) begin
            checks++;
            errors++;
            $display("FAIL %s: entry %0d missing expected %h", name, idx, exp);
        end else begin
            chk(name, use_pop ? pop_log[idx] : req_log[idx], exp);
        end
    endtask

    function automatic int pops_of(input logic [31:0] v);
        int n = 0;
        foreach (pop_log[i]) if (pop_log[i] == v) n++;
        return n;
    endfunction

    function automatic logic [31:0] model_pc(input logic [31:0] r);
`ifdef IFETCH_ALIGN_CHECK_EN
        return r;
`else
        return r & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        redirect_en = 1'b0; redirect_pc = 32'h0;
        ready_v = 1'b0; redir_v = 1'b0; rpc_v = 32'h0; trig_en = 1'b0; trig_hit = 1'b0;
        mq.delete(); req_log.delete(); ack_log.delete(); pop_log.delete();
        m_next_pc = 32'h0000_3000; m_drop = 1'b0; m_mis = 1'b0;
        prev_hold = 1'b0; prev_addr = 32'h0; wait_cnt = 0; rand_lat = 1'b0; cur_lat = 0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_ir", out_ir, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("rst_mis", 32'(misalign_err), 32'h0);
`endif
        rst = 1'b1;
    endtask

    // One cycle: memory response, stimulus, checks against the model, model update.
    task automatic step();
        bit          ack, pop, redir;
        logic [31:0] data, a;
        @(negedge clk);
        a   = imem_addr;
        ack = 1'b0;
        if (imem_req) begin
            if (wait_cnt >= cur_lat) ack = 1'b1;
            else wait_cnt++;
        end
        data  = $urandom;
        redir = redir_v;
        if (trig_en && imem_req && a == trig_addr && ack == trig_ack) begin
            redir = 1'b1; rpc_v = trig_pc; trig_en = 1'b0; trig_hit = 1'b1;
        end
        imem_ack = ack; imem_rdata = data; out_ready = ready_v;
        redirect_en = redir; redirect_pc = rpc_v;

        if (prev_hold) begin
            chk("req_hold", 32'(imem_req), 32'h1);
            chk("addr_hold", a, prev_addr);
        end else if (imem_req) begin
            req_log.push_back(a);
            chk("req_addr", a, m_next_pc);
            chk("req_room", 32'(mq.size() < DEPTH), 32'h1);
            chk("req_when_mis", 32'(m_mis), 32'h0);
        end else if (!m_mis && mq.size() < DEPTH) begin
            chk("req_idle", 32'(imem_req), 32'h1);
        end
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_ir", out_ir, mq[0].ir);
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
`endif

        pop = ready_v && mq.size() != 0;
        if (ack) ack_log.push_back(a);
        if (redir) begin
            mq.delete();
            if (ack) m_drop = 1'b0;
            else if (imem_req) m_drop = 1'b1;
            m_mis = (model_pc(rpc_v) & 32'h3) != 32'h0;
            m_next_pc = model_pc(rpc_v);
        end else begin
            if (pop) begin
                pop_log.push_back(mq[0].pc);
                void'(mq.pop_front());
            end
            if (ack) begin
                if (m_drop) begin
                    m_drop = 1'b0;
                end else begin
                    chk("fifo_room", 32'(mq.size() < DEPTH), 32'h1);
                    mq.push_back('{pc: a, ir: data});
                    m_next_pc = a + 32'd4;
                end
            end
        end
        if (ack) begin
            wait_cnt = 0;
            if (rand_lat) cur_lat = $urandom_range(3, 0);
        end
        prev_hold = imem_req && !ack;
        prev_addr = a;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int r0, p0;
        logic [31:0] r;

        // 1: same-cycle acks, one word per cycle
        do_reset();
        ready_v = 1'b1;
        run(8);
        chk("t1_nreq", 32'(req_log.size()), 32'd8);
        chk("t1_npop", 32'(pop_log.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk_idx("t1_addr", 1'b0, i, 32'h3000 + 32'(4 * i));
            chk_idx("t1_pop", 1'b1, i, 32'h3000 + 32'(4 * i));
        end

        // 2: back-pressure fills the buffer, then drains in order
        do_reset();
        run(10);
        chk("t2_acks", 32'(ack_log.size()), 32'd4);
        chk("t2_req_off", 32'(imem_req), 32'h0);
        ready_v = 1'b1;
        run(8);
        for (int i = 0; i < 4; i++) chk_idx("t2_pop", 1'b1, i, 32'h3000 + 32'(4 * i));
        chk_idx("t2_resume", 1'b0, 4, 32'h3010);

        // 3: redirect while a slow request is pending
        do_reset();
        cur_lat = 3; ready_v = 1'b1;
        trig_en = 1'b1; trig_addr = 32'h3008; trig_ack = 1'b0; trig_pc = 32'h3100;
        for (int i = 0; i < 40 && !trig_hit; i++) step();
        chk("t3_trig", 32'(trig_hit), 32'h1);
        r0 = req_log.size(); p0 = pop_log.size();
        step();
        chk("t3_empty", 32'(out_valid), 32'h0);
        run(20);
        chk_idx("t3_next_req", 1'b0, r0, 32'h3100);
        chk_idx("t3_next_pop", 1'b1, p0, 32'h3100);
        chk("t3_dropped", 32'(pops_of(32'h3008)), 32'h0);

        // 4: redirect coinciding with an ack and a pop
        do_reset();
        ready_v = 1'b1;
        trig_en = 1'b1; trig_addr = 32'h3008; trig_ack = 1'b1; trig_pc = 32'h3400;
        for (int i = 0; i < 20 && !trig_hit; i++) step();
        chk("t4_trig", 32'(trig_hit), 32'h1);
        r0 = req_log.size(); p0 = pop_log.size();
        step();
        chk("t4_empty", 32'(out_valid), 32'h0);
        run(6);
        chk_idx("t4_next_req", 1'b0, r0, 32'h3400);
        chk_idx("t4_next_pop", 1'b1, p0, 32'h3400);
        chk("t4_dropped", 32'(pops_of(32'h3008)), 32'h0);

        // 5: redirect vector table, including address wrap
        tbl.push_back('{32'h0000_3100, 32'h0000_3100, 32'h0000_3104});
        tbl.push_back('{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000});
        tbl.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0004});
        tbl.push_back('{32'h7FFF_FFFC, 32'h7FFF_FFFC, 32'h8000_0000});
`ifndef IFETCH_ALIGN_CHECK_EN
        tbl.push_back('{32'h0000_3102, 32'h0000_3100, 32'h0000_3104});
        tbl.push_back('{32'h0000_5557, 32'h0000_5554, 32'h0000_5558});
`endif
        do_reset();
        ready_v = 1'b1;
        run(3);
        foreach (tbl[k]) begin
            redir_v = 1'b1; rpc_v = tbl[k].rpc;
            step();
            redir_v = 1'b0;
            r0 = req_log.size(); p0 = pop_log.size();
            run(4);
            chk_idx("tbl_a0", 1'b0, r0, tbl[k].a0);
            chk_idx("tbl_a1", 1'b0, r0 + 1, tbl[k].a1);
            chk_idx("tbl_pop", 1'b1, p0, tbl[k].a0);
        end

`ifdef IFETCH_ALIGN_CHECK_EN
        // 6: misaligned redirect halts fetch until an aligned one
        do_reset();
        ready_v = 1'b1;
        run(3);
        redir_v = 1'b1; rpc_v = 32'h3102;
        step();
        redir_v = 1'b0;
        step();
        chk("t6_mis_set", 32'(misalign_err), 32'h1);
        chk("t6_req_off", 32'(imem_req), 32'h0);
        run(3);
        chk("t6_req_still_off", 32'(imem_req), 32'h0);
        redir_v = 1'b1; rpc_v = 32'h3200;
        step();
        redir_v = 1'b0;
        r0 = req_log.size();
        run(3);
        chk("t6_mis_clr", 32'(misalign_err), 32'h0);
        chk_idx("t6_resume", 1'b0, r0, 32'h3200);
`endif

        // Random run against the model
        do_reset();
        rand_lat = 1'b1; cur_lat = $urandom_range(3, 0);
        for (int i = 0; i < 3000; i++) begin
            ready_v = ($urandom_range(3, 0) != 0);
            redir_v = ($urandom_range(24, 0) == 0);
            r = $urandom;
            case ($urandom_range(3, 0))
                0: rpc_v = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
                1: rpc_v = r & 32'h0000_000F;
                default: rpc_v = r;
            endcase
`ifdef IFETCH_ALIGN_CHECK_EN
            rpc_v = rpc_v & 32'hFFFF_FFFC;
`endif
            step();
        end
        redir_v = 1'b0;
        ready_v = 1'b1;
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
